// File: rtl/requantizer_pkg.sv
// rtl/requantizer_pkg.sv - shared saturation limits and rounding modes for the requantizer datapath
package requantizer_pkg;

  // Only half-up rounding exists today; the enum leaves room for more modes.
  typedef enum logic [0:0] {
    ROUND_HALF_UP = 1'b0
  } round_mode_e;

  // Largest value representable in a w-bit signed word.
  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Smallest value representable in a w-bit signed word.
  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/requantizer_sat_narrow.sv
// rtl/requantizer_sat_narrow.sv - combinational shift, optional ReLU and clamp to a narrower signed word
module sat_narrow
  import requantizer_pkg::*;
#(
  parameter int WIDTH     = 33,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 8,
  parameter int RELU      = 0
) (
  input  logic signed [WIDTH-1:0]     value,
  output logic signed [OUT_WIDTH-1:0] data,
  output logic                        sat
);

  localparam logic signed [WIDTH-1:0]     max_q = WIDTH'(sat_max(OUT_WIDTH));
  localparam logic signed [WIDTH-1:0]     min_q = WIDTH'(sat_min(OUT_WIDTH));
  localparam logic signed [OUT_WIDTH-1:0] max_d = OUT_WIDTH'(sat_max(OUT_WIDTH));
  localparam logic signed [OUT_WIDTH-1:0] min_d = OUT_WIDTH'(sat_min(OUT_WIDTH));

  logic signed [WIDTH-1:0] q;

  assign q = value >>> SHIFT;

  // ReLU takes priority over clamping, so a clipped negative never counts as saturation.
  always_comb begin
    data = q[OUT_WIDTH-1:0];
    sat  = 1'b0;
    if (RELU != 0 && q < 0) begin
      data = '0;
    end else if (q > max_q) begin
      data = max_d;
      sat  = 1'b1;
    end else if (q < min_q) begin
      data = min_d;
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/requantizer.sv
// rtl/requantizer.sv - two-stage round/narrow pipeline with valid/ready handshakes and saturation counter
module requantizer
  import requantizer_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 8,
  parameter int RELU      = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_sat,
  input  logic                        sat_clear,
  output logic [CNT_WIDTH-1:0]        sat_count
);

  // One guard bit keeps the rounding add from wrapping at the positive extreme.
  localparam int rw = IN_WIDTH + 1;
  localparam int rs = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [rw-1:0] rnd_bias = (SHIFT > 0) ? (rw'(1) <<< rs) : '0;

  logic                        s1_valid;
  logic signed [rw-1:0]        r1;
  logic signed [rw-1:0]        rounded;
  logic                        s2_valid;
  logic                        s1_load;
  logic                        s2_load;
  logic signed [OUT_WIDTH-1:0] narrow_data;
  logic                        narrow_sat;
  logic                        out_fire;

  // A stage loads when empty or when the stage after it drains this cycle.
  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;
  assign out_fire  = s2_valid && out_ready;

  assign rounded = $signed({in_data[IN_WIDTH-1], in_data}) + rnd_bias;

  sat_narrow #(
    .WIDTH     (rw),
    .OUT_WIDTH (OUT_WIDTH),
    .SHIFT     (SHIFT),
    .RELU      (RELU)
  ) u_narrow (
    .value (r1),
    .data  (narrow_data),
    .sat   (narrow_sat)
  );

  // Stage 1: capture the rounded sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      r1       <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      r1       <= rounded;
    end
  end

  // Stage 2: capture the narrowed word; held while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      out_data <= narrow_data;
      out_sat  <= s1_valid && narrow_sat;
    end
  end

  // Saturation event counter: clear wins, otherwise count delivered saturations and stick at max.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count <= '0;
    end else if (sat_clear) begin
      sat_count <= '0;
    end else if (out_fire && out_sat && sat_count != '1) begin
      sat_count <= sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_requantizer.sv
// tb/tb_requantizer.sv - randomized self-checking bench for requantizer against an arithmetic model
module tb_requantizer;

  localparam int IW = 32;
  localparam int OW = 16;
  localparam int SH = 8;
  localparam int CW = 16;
  localparam longint CMAX = (longint'(1) << CW) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic signed [IW-1:0] in_data;
  logic                 out_ready;
  logic                 sat_clear;
  logic                 in_ready, in_ready_r;
  logic                 out_valid, out_valid_r;
  logic signed [OW-1:0] out_data, out_data_r;
  logic                 out_sat, out_sat_r;
  logic [CW-1:0]        sat_count, sat_count_r;

  requantizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT(SH), .RELU(0), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .sat_clear(sat_clear), .sat_count(sat_count)
  );

  requantizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT(SH), .RELU(1), .CNT_WIDTH(CW)) dut_relu (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r), .in_data(in_data),
    .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r), .out_sat(out_sat_r),
    .sat_clear(sat_clear), .sat_count(sat_count_r)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: round half toward +inf via floor division, then ReLU and clamp.
  function automatic void ref_quant(input longint x, input bit relu, output longint d, output bit s);
    longint div = longint'(1) << SH;
    longint v   = x + (div / 2);
    longint q   = (v >= 0) ? v / div : -((-v + div - 1) / div);
    d = q;
    s = 1'b0;
    if (relu && q < 0) d = 0;
    else if (q > 32767) begin d = 32767; s = 1'b1; end
    else if (q < -32768) begin d = -32768; s = 1'b1; end
  endfunction

  typedef struct { longint x; int cyc; } entry_t;
  entry_t sb[$];
  longint got_d[$];
  longint got_dr[$];
  bit     got_s[$];
  bit     got_sr[$];

  int     cyc = 0;
  int     occ;
  longint m_cnt, m_cnt_r;
  bit     chk_lat, rand_ready;
  bit     hold;
  longint hold_d;
  bit     hold_s;
  entry_t mon_e;
  longint mon_d, mon_dr;
  bit     mon_s, mon_sr, mon_fire;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      occ = 0; m_cnt = 0; m_cnt_r = 0; hold = 1'b0;
    end else begin
      check_val("in_ready", in_ready, (occ == 2 && !out_ready) ? 0 : 1);
      check_val("in_ready_relu", in_ready_r, (occ == 2 && !out_ready) ? 0 : 1);
      if (occ == 0) begin
        check_val("idle_out_valid", out_valid, 0);
        check_val("idle_out_valid_relu", out_valid_r, 0);
      end
      check_val("sat_count", sat_count, m_cnt);
      check_val("sat_count_relu", sat_count_r, m_cnt_r);
      if (hold) begin
        check_val("hold_valid", out_valid, 1);
        check_val("hold_data", out_data, hold_d);
        check_val("hold_sat", out_sat, hold_s);
      end
      hold   = out_valid && !out_ready;
      hold_d = out_data;
      hold_s = out_sat;
      mon_fire = out_valid && out_ready;
      mon_s = 1'b0; mon_sr = 1'b0;
      if (mon_fire) begin
        check_val("scoreboard_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          ref_quant(mon_e.x, 1'b0, mon_d, mon_s);
          ref_quant(mon_e.x, 1'b1, mon_dr, mon_sr);
          check_val("out_data", out_data, mon_d);
          check_val("out_sat", out_sat, mon_s);
          check_val("relu_valid", out_valid_r, 1);
          check_val("relu_data", out_data_r, mon_dr);
          check_val("relu_sat", out_sat_r, mon_sr);
          if (chk_lat) check_val("latency", cyc - mon_e.cyc, 2);
          got_d.push_back(out_data);  got_s.push_back(out_sat);
          got_dr.push_back(out_data_r); got_sr.push_back(out_sat_r);
          occ--;
        end
      end
      if (sat_clear) m_cnt = 0;
      else if (mon_fire && mon_s && m_cnt < CMAX) m_cnt++;
      if (sat_clear) m_cnt_r = 0;
      else if (mon_fire && mon_sr && m_cnt_r < CMAX) m_cnt_r++;
      if (in_valid && in_ready) begin
        sb.push_back('{longint'(in_data), cyc});
        occ++;
      end
    end
  end

  // Background random backpressure.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [IW-1:0] x);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = x;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
      if (ok) break;
    end
    check_val("send_accept", ok, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 5000 && sb.size() != 0; t++) @(posedge clk);
    #1;
    check_val("drain_empty", sb.size(), 0);
  endtask

  task automatic clear_got();
    got_d.delete(); got_s.delete(); got_dr.delete(); got_sr.delete();
  endtask

  function automatic logic [IW-1:0] rand_val();
    int sel = $urandom_range(0, 2);
    if (sel == 0) return $urandom;
    if (sel == 1) return IW'(int'($urandom_range(0, (1 << 24) - 1)) - (1 << 23));
    return IW'((int'($urandom_range(0, 200)) - 100) * 256 + 128);
  endfunction

  longint exp_round [4] = '{2, 3, -2, 0};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    sat_clear = 1'b0; rand_ready = 1'b0; chk_lat = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_sat_count", sat_count, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_out_sat", out_sat, 0);
    rst = 1'b0;

    // Rounding
    out_ready = 1'b1; chk_lat = 1'b1; clear_got();
    send(384); send(640); send(-640); send(0);
    drain();
    check_val("round_count", got_d.size(), 4);
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      check_val("round_data", got_d[i], exp_round[i]);
      check_val("round_sat", got_s[i], 0);
    end

    // Saturation
    sat_clear = 1'b1; @(posedge clk); #1; sat_clear = 1'b0;
    clear_got();
    send(32'h7FFF_FFFF); send(32'h8000_0000);
    drain();
    check_val("sat_count_n", got_d.size(), 2);
    if (got_d.size() == 2) begin
      check_val("sat_pos", got_d[0], 32767);
      check_val("sat_neg", got_d[1], -32768);
      check_val("sat_pos_flag", got_s[0], 1);
      check_val("sat_neg_flag", got_s[1], 1);
    end
    check_val("sat_count_two", sat_count, 2);

    // ReLU instance
    clear_got();
    send(-100000); send(1000);
    drain();
    check_val("relu_n", got_dr.size(), 2);
    if (got_dr.size() == 2) begin
      check_val("relu_neg", got_dr[0], 0);
      check_val("relu_pos", got_dr[1], 4);
      check_val("relu_sat0", got_sr[0], 0);
      check_val("relu_sat1", got_sr[1], 0);
    end
    chk_lat = 1'b0;

    // Backpressure with a 5-cycle stall
    clear_got(); rand_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(IW'(i * 256));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    rand_ready = 1'b0; out_ready = 1'b0;
    send(IW'(5 * 256)); send(IW'(6 * 256));
    check_val("in_ready_full", in_ready, 0);
    repeat (5) @(posedge clk);
    #1;
    check_val("stall_valid", out_valid, 1);
    out_ready = 1'b1;
    #1;
    check_val("in_ready_restart", in_ready, 1);
    rand_ready = 1'b1;
    for (int i = 7; i < 10; i++) send(IW'(i * 256));
    drain();
    check_val("bp_count", got_d.size(), 10);
    for (int i = 0; i < 10 && i < got_d.size(); i++) check_val("bp_order", got_d[i], i);

    // Random traffic
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      send(rand_val());
    end
    drain();
    rand_ready = 1'b0; out_ready = 1'b1;

    // Counter: clear collides with a saturated transfer
    sat_clear = 1'b1; @(posedge clk); #1; sat_clear = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h7FFF_FFFF);
    drain();
    check_val("cnt_three", sat_count, 3);
    out_ready = 1'b0;
    send(32'h7FFF_FFFF);
    for (int t = 0; t < 20 && !out_valid; t++) begin @(posedge clk); #1; end
    check_val("cnt_pending", out_valid, 1);
    sat_clear = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    sat_clear = 1'b0;
    check_val("cnt_clear_wins", sat_count, 0);
    check_val("cnt_clear_drained", sb.size(), 0);

    // Counter sticks at its maximum
    for (int i = 0; i < 65541; i++) send(i[0] ? 32'h8000_0000 : 32'h7FFF_FFFF);
    drain();
    check_val("cnt_sticky", sat_count, 65535);

    // Mid-stream reset
    out_ready = 1'b0;
    send(1000); send(2000);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("mrst_out_valid", out_valid, 0);
    check_val("mrst_sat_count", sat_count, 0);
    check_val("mrst_in_ready", in_ready, 1);
    check_val("mrst_relu_valid", out_valid_r, 0);
    rst = 1'b0; out_ready = 1'b1; clear_got();
    send(IW'(3 * 256)); send(IW'(4 * 256));
    drain();
    check_val("mrst_count", got_d.size(), 2);
    if (got_d.size() == 2) begin
      check_val("mrst_first", got_d[0], 3);
      check_val("mrst_second", got_d[1], 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
